conv_arbiter: RTL and testbench
===============================

# conv_arbiter

Two-port round-robin arbiter and sequencer in front of the serial 6-bit convolution engine, which computes the peak of the binary convolution of A and B. It accepts operand pairs from two requesters, grants one at a time, and drives the engine's operand and start pins. It waits for the engine to finish, then returns the 4-bit result tagged with the requester id on a shared response channel. It sits between the chip-level input logic and the convolution engine instance.

## Interface
Parameters:
- `OP_W`, 6: operand width (A and B).
- `RES_W`, 4: result width.
- `TIMEOUT_CYCLES`, 32: engine watchdog limit. Used only with `CONV_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operand pair.
- `req0_ready` / `req1_ready`  out  1  grant; the operand pair is taken on a valid&ready edge.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  OP_W  operands.
- `eng_start`  out  1  single-cycle start pulse to the engine.
- `eng_a`, `eng_b`  out  OP_W  operands to the engine, held stable from ISSUE through WAIT.
- `eng_done`  in  1  single-cycle completion pulse from the engine.
- `eng_result`  in  RES_W  engine result, valid with `eng_done`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_data`  out  RES_W  result.
- `rsp_err`  out  1  watchdog expiry flag; constant 0 without the macro.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - `req_ready` of the winner only is asserted combinationally in IDLE.
  - On the handshake edge: capture a, b and id into operand/id registers, update `last_grant`, go to ISSUE.
- ISSUE: `eng_start`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On `eng_done`: capture `eng_result` into `rsp_data`, go to RESP.
  - `eng_done` in any other state is ignored.
- RESP:
  - `rsp_valid`=1 with stable `rsp_id`/`rsp_data`/`rsp_err` until `rsp_ready`.
  - On the `rsp_valid`&`rsp_ready` edge, go to IDLE.
- Only one job is in flight at a time. Both `req_ready` stay low outside IDLE.
- Requester inputs may change freely while the requester is not granted.

## Timing
- Reset values (asynchronous):
  - FSM in IDLE.
  - `eng_start`=0, `eng_a`=`eng_b`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - Watchdog counter=0.
- Handshake edge to `eng_start` high: 1 cycle.
- `eng_done` edge to `rsp_valid` high: 1 cycle.
- Minimum turnaround per job: 3 cycles plus engine latency plus response stall.
- A new request is accepted no earlier than the cycle after the response handshake; there is no IDLE bypass.
- Reset asserted mid-operation:
  - The job is dropped and no response is issued.
  - The engine's own reset aborts it.
  - A stale `eng_done` after reset release is ignored because the FSM is in IDLE.
- `eng_done` in the same cycle as `eng_start`: ignored. `eng_done` is only sampled in WAIT.
- Both requesters valid on consecutive jobs: grants strictly alternate 0, 1, 0, 1.

## Configuration
- Macro `CONV_ARB_TIMEOUT_EN`.
- Defined:
  - The watchdog counts cycles in WAIT; it clears on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `eng_done`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `eng_done` arriving in the same cycle as expiry wins: normal response, `rsp_err`=0.
- Undefined:
  - No counter is built and `rsp_err` is tied to 0.
  - WAIT persists until `eng_done`.

## Test plan
- Single request: `req0` a=6'b110110, b=6'b110110 with a behavioural engine of 20-cycle latency returning the convolution peak.
  - One `eng_start` pulse, eng_a/eng_b=6'b110110.
  - Response `rsp_id`=0, `rsp_data`=4'b0100, `rsp_err`=0.
- Tie from reset: both valid, req0 a=b=6'b111111 (peak 6), req1 a=6'b000001, b=6'b000001 (peak 1).
  - Grants in order 0 then 1.
  - Responses (id 0, 4'b0110) then (id 1, 4'b0001).
- Back-to-back contention: both held valid for 4 jobs → grant order 0, 1, 0, 1 and exactly 4 `eng_start` pulses.
- Response backpressure: `rsp_ready` held low for 10 cycles.
  - `rsp_valid` and data stay stable.
  - `req_ready` stays low until the response handshake.
- Async reset during WAIT: `reset_n` pulled low 5 cycles after `eng_start`.
  - All outputs return to reset values immediately.
  - A late `eng_done` produces no response.
- With `CONV_ARB_TIMEOUT_EN`, engine never asserts done, `TIMEOUT_CYCLES`=32.
  - `rsp_valid` rises 33 cycles after `eng_start` with `rsp_err`=1, `rsp_data`=0.
  - Without the macro, no response after 200 cycles.

Source files
------------

// File: rtl/conv_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the serial convolution engine.
// Optional engine watchdog is built only when CONV_ARB_TIMEOUT_EN is defined.

module conv_arbiter #(
  parameter int unsigned OP_W           = 6,
  parameter int unsigned RES_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_a,
  input  logic [OP_W-1:0]  req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_a,
  input  logic [OP_W-1:0]  req1_b,
  output logic             eng_start,
  output logic [OP_W-1:0]  eng_a,
  output logic [OP_W-1:0]  eng_b,
  input  logic             eng_done,
  input  logic [RES_W-1:0] eng_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic             eng_start_q;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [RES_W-1:0] rsp_data_q;

  logic win_valid;
  logic win_id;
  logic expire;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    win_valid = req0_valid | req1_valid;
    win_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      win_id = ~last_grant_q;
    end else if (req1_valid) begin
      win_id = 1'b1;
    end
  end

  assign req0_ready = (state_q == StIdle) && win_valid && !win_id;
  assign req1_ready = (state_q == StIdle) && win_valid && win_id;

`ifdef CONV_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wdog_q;
  logic            rsp_err_q;

  assign expire = (state_q == StWait) && (wdog_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wdog_q <= '0;
      end else if (state_q == StWait) begin
        wdog_q <= wdog_q + CntW'(1);
      end
      // A done pulse coinciding with expiry takes priority over the error.
      if (state_q == StWait) begin
        if (eng_done) begin
          rsp_err_q <= 1'b0;
        end else if (expire) begin
          rsp_err_q <= 1'b1;
        end
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      eng_start_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      eng_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            a_q          <= win_id ? req1_a : req0_a;
            b_q          <= win_id ? req1_b : req0_b;
            rsp_id_q     <= win_id;
            last_grant_q <= win_id;
            eng_start_q  <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (eng_done) begin
            rsp_data_q  <= eng_result;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (expire) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign eng_start = eng_start_q;
  assign eng_a     = a_q;
  assign eng_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_conv_arbiter.sv
// Self-checking bench for conv_arbiter with a behavioural 20-cycle convolution engine.
// Define CONV_ARB_TIMEOUT_EN for both files to exercise the watchdog path.

module tb_conv_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [5:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       eng_start;
  logic [5:0] eng_a, eng_b;
  logic       eng_done;
  logic [3:0] eng_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic       rsp_err;

  conv_arbiter #(.OP_W(6), .RES_W(4), .TIMEOUT_CYCLES(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v0, v1;
    logic [5:0] a0, b0, a1, b1;
    logic       id;
    logic [3:0] data;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] data;
    logic       err;
  } rsp_t;

  rsp_t       exp_q[$];
  rsp_t       mon_e;
  vec_t       vec [8];
  int         checks = 0;
  int         passed = 0;
  int         starts = 0;
  logic [5:0] exp_a = '0, exp_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push_exp(input logic id, input logic [3:0] data, input logic err);
    rsp_t r;
    r.id = id;
    r.data = data;
    r.err = err;
    exp_q.push_back(r);
  endtask

  function automatic logic [3:0] peak(input logic [5:0] a, input logic [5:0] b);
    int best;
    int s;
    best = 0;
    for (int k = 0; k < 11; k++) begin
      s = 0;
      for (int i = 0; i < 6; i++) begin
        if (k - i >= 0 && k - i < 6) begin
          if (a[i] && b[k-i]) s++;
        end
      end
      if (s > best) best = s;
    end
    return best[3:0];
  endfunction

  // Behavioural engine: result appears with a done pulse ~20 cycles after start.
  logic       eng_dead = 1'b0;
  logic       inj_done = 1'b0;
  logic       model_done;
  logic [3:0] model_res;
  int         model_cnt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_done <= 1'b0;
      model_res  <= '0;
      model_cnt  <= 0;
    end else begin
      model_done <= 1'b0;
      if (eng_start && !eng_dead) begin
        model_cnt <= 20;
        model_res <= peak(eng_a, eng_b);
      end else if (model_cnt != 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) model_done <= 1'b1;
      end
    end
  end

  assign eng_done   = model_done | inj_done;
  assign eng_result = model_res;

  always @(negedge clock) begin
    if (reset_n && eng_start) begin
      starts++;
      check("eng_a_at_start", eng_a, exp_a);
      check("eng_b_at_start", eng_b, exp_b);
    end
  end

  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  task automatic wait_grant(input string name, input logic exp_id);
    int n;
    n = 0;
    @(negedge clock);
    while (!(req0_ready || req1_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      check({name, "_grant_timeout"}, 1, 0);
    end else begin
      check({name, "_onehot"}, req0_ready & req1_ready, 0);
      check({name, "_grant_id"}, req1_ready, exp_id);
    end
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!eng_start && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check({name, "_start_timeout"}, 1, 0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int s2;
    int n;
    logic saw;

    vec[0] = '{1'b1, 1'b1, 6'h3F, 6'h3F, 6'h01, 6'h01, 1'b0, 4'd6};
    vec[1] = '{1'b1, 1'b1, 6'h3F, 6'h3F, 6'h01, 6'h01, 1'b1, 4'd1};
    vec[2] = '{1'b1, 1'b1, 6'h3F, 6'h3F, 6'h01, 6'h01, 1'b0, 4'd6};
    vec[3] = '{1'b1, 1'b1, 6'h3F, 6'h3F, 6'h01, 6'h01, 1'b1, 4'd1};
    vec[4] = '{1'b1, 1'b1, 6'h3F, 6'h3F, 6'h01, 6'h01, 1'b0, 4'd6};
    vec[5] = '{1'b1, 1'b1, 6'h3F, 6'h3F, 6'h01, 6'h01, 1'b1, 4'd1};
    vec[6] = '{1'b1, 1'b0, 6'b110110, 6'b110110, 6'h00, 6'h00, 1'b0, 4'b0100};
    vec[7] = '{1'b0, 1'b1, 6'h00, 6'h00, 6'b000011, 6'b000011, 1'b1, 4'd2};
    s2 = 0;

    // Reset state.
    @(negedge clock);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_eng_b", eng_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req0_ready", req0_ready, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Table: tie from reset, 4-job contention, then single requests.
    for (int i = 0; i < 8; i++) begin
      req0_valid = vec[i].v0;
      req1_valid = vec[i].v1;
      req0_a = vec[i].a0;
      req0_b = vec[i].b0;
      req1_a = vec[i].a1;
      req1_b = vec[i].b1;
      wait_grant($sformatf("vec%0d", i), vec[i].id);
      if (i == 2) s2 = starts;
      if (i == 6) check("contention_start_count", starts - s2, 4);
      exp_a = vec[i].id ? vec[i].a1 : vec[i].a0;
      exp_b = vec[i].id ? vec[i].b1 : vec[i].b0;
      push_exp(vec[i].id, vec[i].data, 1'b0);
      @(posedge clock); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain("table");
    check("table_start_count", starts, 8);

    // Response backpressure: req0 waits behind a stalled req1 response.
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    req1_valid = 1'b1;
    req1_a = 6'h3F;
    req1_b = 6'h3F;
    wait_grant("bp", 1'b1);
    exp_a = 6'h3F;
    exp_b = 6'h3F;
    push_exp(1'b1, 4'd6, 1'b0);
    @(posedge clock); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_a = 6'b101010;
    req0_b = 6'b101010;
    n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("bp_rsp_arrives", rsp_valid, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("bp_rsp_valid_held", rsp_valid, 1);
      check("bp_rsp_data_held", rsp_data, 6);
      check("bp_rsp_id_held", rsp_id, 1);
      check("bp_req0_ready_low", req0_ready, 0);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_req0_ready_at_handshake", req0_ready, 0);
    @(negedge clock);
    check("bp_req0_ready_after_handshake", req0_ready, 1);
    exp_a = 6'b101010;
    exp_b = 6'b101010;
    @(posedge clock); #1;
    req0_valid = 1'b0;

    // Asynchronous reset 5 cycles into the wait; job must vanish.
    wait_start("rst");
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_eng_start", eng_start, 0);
    check("midrst_eng_a", eng_a, 0);
    check("midrst_eng_b", eng_b, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_id", rsp_id, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_rsp_err", rsp_err, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    inj_done = 1'b1;
    @(posedge clock); #1;
    inj_done = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      saw = saw | rsp_valid;
    end
    check("late_done_no_rsp", saw, 0);

    // Tie right after reset goes to requester 0 again.
    @(posedge clock); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = 6'b000111;
    req0_b = 6'b000111;
    req1_a = 6'b000001;
    req1_b = 6'b000001;
    wait_grant("post_rst_tie", 1'b0);
    exp_a = 6'b000111;
    exp_b = 6'b000111;
    push_exp(1'b0, 4'd3, 1'b0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain("post_rst");

    // Engine that never finishes.
    @(posedge clock); #1;
    eng_dead = 1'b1;
    req1_valid = 1'b1;
    req1_a = 6'b011000;
    req1_b = 6'b011000;
    wait_grant("wdog", 1'b1);
    exp_a = 6'b011000;
    exp_b = 6'b011000;
`ifdef CONV_ARB_TIMEOUT_EN
    push_exp(1'b1, 4'd0, 1'b1);
`endif
    @(posedge clock); #1;
    req1_valid = 1'b0;
    wait_start("wdog");
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
`ifdef CONV_ARB_TIMEOUT_EN
    check("wdog_latency", n, 33);
    drain("wdog");
`else
    check("no_rsp_without_wdog", rsp_valid, 0);
`endif
    check("total_start_count", starts, 12);
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
